// File: rtl/serial_frame_pkg.sv
// Shared types and default geometry for the serial frame receive controller.
package serial_frame_pkg;

   localparam int unsigned DefaultPatW  = 4;
   localparam int unsigned DefaultAddrW = 2;
   localparam int unsigned DefaultLenW  = 4;

   localparam logic [DefaultPatW-1:0] DefaultStartPat = 4'b1011;

   typedef enum logic [1:0] {
      StHunt    = 2'd0,
      StAddr    = 2'd1,
      StLen     = 2'd2,
      StPayload = 2'd3
   } state_e;

endpackage

// File: rtl/start_pattern_det.sv
// Start-pattern hunter: shift register with a combinational match that includes the incoming bit.
module start_pattern_det
   import serial_frame_pkg::*;
#(
   parameter int unsigned      PAT_W     = DefaultPatW,
   parameter logic [PAT_W-1:0] START_PAT = DefaultStartPat
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic shift_en_i,
   input  logic clr_i,
   input  logic bit_i,
   output logic match_o
);

   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PAT_W-1:0] pat_shifted;

   assign pat_shifted = {pat_q[PAT_W-2:0], bit_i};

   always_comb begin
      pat_d = pat_q;
      if (clr_i) begin
         pat_d = '0;
      end else if (shift_en_i) begin
         pat_d = pat_shifted;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pat_q <= '0;
      end else begin
         pat_q <= pat_d;
      end
   end

   // Overlapping detection: older bits stay in the window after a miss.
   assign match_o = shift_en_i && !clr_i && (pat_shifted == START_PAT);

endmodule

// File: rtl/serial_frame_ctrl.sv
// Serial frame controller: hunts a start pattern, captures address and length fields,
// then streams the payload bits to the addressed port with a completion pulse.
module serial_frame_ctrl
   import serial_frame_pkg::*;
#(
   parameter int unsigned      PAT_W     = DefaultPatW,
   parameter logic [PAT_W-1:0] START_PAT = DefaultStartPat,
   parameter int unsigned      ADDR_W    = DefaultAddrW,
   parameter int unsigned      LEN_W     = DefaultLenW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ser_in,
   input  logic                 bit_valid,
   input  logic                 abort,
   input  logic [2**ADDR_W-1:0] port_en,
   output logic                 out_bit,
   output logic [2**ADDR_W-1:0] out_valid,
   output logic [ADDR_W-1:0]    cur_port,
   output logic                 frame_done,
   output logic                 dropped,
   output logic                 busy
);

   localparam int unsigned NPORTS      = 2**ADDR_W;
   localparam int unsigned MaxFieldW   = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
   localparam int unsigned CNT_W       = $clog2(MaxFieldW + 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_sr_q, addr_sr_d;
   logic [LEN_W-1:0]    len_sr_q, len_sr_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0]    pay_cnt_q, pay_cnt_d;
   logic [ADDR_W-1:0]   cur_port_q, cur_port_d;
   logic                out_bit_q, out_bit_d;
   logic [NPORTS-1:0]   out_valid_q, out_valid_d;
   logic                frame_done_q, frame_done_d;
   logic                dropped_q, dropped_d;

   logic [ADDR_W-1:0]   addr_next;
   logic [LEN_W-1:0]    len_next;
   logic                det_shift_en;
   logic                det_clr;
   logic                det_match;

   // Holding the detector cleared outside HUNT guarantees an empty window on re-entry.
   assign det_shift_en = bit_valid && (state_q == StHunt);
   assign det_clr      = abort || (state_q != StHunt);

   start_pattern_det #(
      .PAT_W     (PAT_W),
      .START_PAT (START_PAT)
   ) u_start_det (
      .clk_i      (clk),
      .rst_i      (rst),
      .shift_en_i (det_shift_en),
      .clr_i      (det_clr),
      .bit_i      (ser_in),
      .match_o    (det_match)
   );

   assign addr_next = {addr_sr_q[ADDR_W-2:0], ser_in};
   assign len_next  = {len_sr_q[LEN_W-2:0], ser_in};

   always_comb begin
      state_d      = state_q;
      addr_sr_d    = addr_sr_q;
      len_sr_d     = len_sr_q;
      bit_cnt_d    = bit_cnt_q;
      pay_cnt_d    = pay_cnt_q;
      cur_port_d   = cur_port_q;
      out_bit_d    = out_bit_q;
      out_valid_d  = '0;
      frame_done_d = 1'b0;
      dropped_d    = 1'b0;

      if (abort) begin
         state_d   = StHunt;
         addr_sr_d = '0;
         len_sr_d  = '0;
         bit_cnt_d = '0;
         pay_cnt_d = '0;
      end else if (bit_valid) begin
         unique case (state_q)
            StHunt: begin
               if (det_match) begin
                  state_d   = StAddr;
                  addr_sr_d = '0;
                  len_sr_d  = '0;
                  bit_cnt_d = '0;
               end
            end
            StAddr: begin
               addr_sr_d = addr_next;
               if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                  cur_port_d = addr_next;
                  bit_cnt_d  = '0;
                  state_d    = StLen;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            StLen: begin
               len_sr_d = len_next;
               if (bit_cnt_q == CNT_W'(LEN_W - 1)) begin
                  bit_cnt_d = '0;
                  if (len_next == '0) begin
                     frame_done_d = 1'b1;
                     dropped_d    = !port_en[cur_port_q];
                     state_d      = StHunt;
                  end else begin
                     pay_cnt_d = len_next;
                     state_d   = StPayload;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            StPayload: begin
               out_bit_d = ser_in;
               if (port_en[cur_port_q]) begin
                  out_valid_d = NPORTS'(1) << cur_port_q;
               end
               pay_cnt_d = pay_cnt_q - 1'b1;
               if (pay_cnt_q == LEN_W'(1)) begin
                  frame_done_d = 1'b1;
                  dropped_d    = !port_en[cur_port_q];
                  state_d      = StHunt;
               end
            end
            default: begin
               state_d = StHunt;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StHunt;
         addr_sr_q    <= '0;
         len_sr_q     <= '0;
         bit_cnt_q    <= '0;
         pay_cnt_q    <= '0;
         cur_port_q   <= '0;
         out_bit_q    <= 1'b0;
         out_valid_q  <= '0;
         frame_done_q <= 1'b0;
         dropped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_sr_q    <= addr_sr_d;
         len_sr_q     <= len_sr_d;
         bit_cnt_q    <= bit_cnt_d;
         pay_cnt_q    <= pay_cnt_d;
         cur_port_q   <= cur_port_d;
         out_bit_q    <= out_bit_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         dropped_q    <= dropped_d;
      end
   end

   assign out_bit    = out_bit_q;
   assign out_valid  = out_valid_q;
   assign cur_port   = cur_port_q;
   assign frame_done = frame_done_q;
   assign dropped    = dropped_q;
   assign busy       = (state_q != StHunt);

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl: a bit-history frame model checked every cycle,
// plus literal expectations per scenario.
module tb_serial_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ser_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] port_en = 4'hF;
   logic       out_bit;
   logic [3:0] out_valid;
   logic [1:0] cur_port;
   logic       frame_done;
   logic       dropped;
   logic       busy;

   always #5 clk = ~clk;

   serial_frame_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .ser_in     (ser_in),
      .bit_valid  (bit_valid),
      .abort      (abort),
      .port_en    (port_en),
      .out_bit    (out_bit),
      .out_valid  (out_valid),
      .cur_port   (cur_port),
      .frame_done (frame_done),
      .dropped    (dropped),
      .busy       (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: hunt window as an integer, frame content as the list of bits after the start.
   bit   m_in_frame = 0;
   int   m_win = 0;
   int   m_fb[$];
   int   m_len = 0;
   int   m_port = 0;

   logic       nxt_bit = 0, exp_bit = 0;
   logic [3:0] nxt_valid = 0, exp_valid = 0;
   int         nxt_port = 0, exp_port = 0;
   bit         nxt_done = 0, exp_done = 0;
   bit         nxt_drop = 0, exp_drop = 0;
   bit         nxt_busy = 0, exp_busy = 0;

   int         lg_nvalid = 0, lg_ndone = 0, lg_ndrop = 0, lg_done_valid = 0;
   logic [15:0] lg_bits = 0;
   logic [3:0] lg_valid = 0;
   int         b_nvalid, b_ndone, b_ndrop, b_done_valid;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void model_step(input bit r, input bit bv, input bit ab, input bit sin,
                                      input logic [3:0] pen);
      int n;
      nxt_valid = '0;
      nxt_done  = 0;
      nxt_drop  = 0;
      nxt_bit   = exp_bit;
      nxt_port  = m_port;
      if (r) begin
         m_in_frame = 0; m_win = 0; m_fb.delete(); m_port = 0;
         nxt_bit = 0; nxt_port = 0;
      end else if (ab) begin
         m_in_frame = 0; m_win = 0; m_fb.delete();
      end else if (bv) begin
         if (!m_in_frame) begin
            m_win = ((m_win << 1) | int'(sin)) & 15;
            if (m_win == 11) begin
               m_in_frame = 1;
               m_fb.delete();
            end
         end else begin
            m_fb.push_back(int'(sin));
            n = m_fb.size();
            if (n == 2) begin
               m_port   = 2 * m_fb[0] + m_fb[1];
               nxt_port = m_port;
            end
            if (n == 6) m_len = 8 * m_fb[2] + 4 * m_fb[3] + 2 * m_fb[4] + m_fb[5];
            if (n > 6) begin
               nxt_bit = sin;
               if (pen[m_port]) nxt_valid = 4'b0001 << m_port;
            end
            if (n >= 6 && n - 6 == m_len) begin
               nxt_done = 1;
               nxt_drop = !pen[m_port];
               m_in_frame = 0;
               m_win = 0;
            end
         end
      end
      nxt_busy = m_in_frame;
   endfunction

   task automatic compare_outputs();
      check("out_bit", int'(out_bit), int'(exp_bit));
      check("out_valid", int'(out_valid), int'(exp_valid));
      check("cur_port", int'(cur_port), exp_port);
      check("frame_done", int'(frame_done), int'(exp_done));
      check("dropped", int'(dropped), int'(exp_drop));
      check("busy", int'(busy), int'(exp_busy));
      if (out_valid != 0) begin
         lg_nvalid++;
         lg_bits  = {lg_bits[14:0], out_bit};
         lg_valid = out_valid;
      end
      if (frame_done) begin
         lg_ndone++;
         if (out_valid != 0) lg_done_valid++;
      end
      if (dropped) lg_ndrop++;
   endtask

   task automatic step(input bit r, input bit bv, input bit ab, input bit sin);
      rst = r; bit_valid = bv; abort = ab; ser_in = sin;
      model_step(r, bv, ab, sin, port_en);
      @(posedge clk);
      #1;
      exp_bit = nxt_bit; exp_valid = nxt_valid; exp_port = nxt_port;
      exp_done = nxt_done; exp_drop = nxt_drop; exp_busy = nxt_busy;
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic send(input int v, input int n, input bit gap);
      for (int i = n - 1; i >= 0; i--) begin
         step(0, 1, 0, v[i]);
         if (gap) step(0, 0, 0, !v[i]);
      end
   endtask

   task automatic frame(input int addr, input int len, input int payload, input bit gap);
      send(11, 4, gap);
      send(addr, 2, gap);
      send(len, 4, gap);
      if (len != 0) send(payload, len, gap);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic mark();
      b_nvalid = lg_nvalid; b_ndone = lg_ndone; b_ndrop = lg_ndrop; b_done_valid = lg_done_valid;
   endtask

   initial begin
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("rst_busy", int'(busy), 0);
      check("rst_out_valid", int'(out_valid), 0);

      // Basic frame twice, back to back
      mark();
      frame(2, 3, 5, 0);
      frame(2, 3, 5, 0);
      idle(2);
      check("basic_nvalid", lg_nvalid - b_nvalid, 6);
      check("basic_bits", int'(lg_bits[5:0]), int'(6'b101101));
      check("basic_valid_mask", int'(lg_valid), 4);
      check("basic_ndone", lg_ndone - b_ndone, 2);
      check("basic_done_with_valid", lg_done_valid - b_done_valid, 2);
      check("basic_cur_port", int'(cur_port), 2);

      // Gapped frame, then zero-length frame
      mark();
      frame(2, 3, 5, 1);
      idle(2);
      check("gap_nvalid", lg_nvalid - b_nvalid, 3);
      check("gap_bits", int'(lg_bits[2:0]), 5);
      check("gap_ndone", lg_ndone - b_ndone, 1);
      mark();
      frame(1, 0, 0, 0);
      idle(2);
      check("zero_ndone", lg_ndone - b_ndone, 1);
      check("zero_nvalid", lg_nvalid - b_nvalid, 0);
      check("zero_cur_port", int'(cur_port), 1);

      // Disabled port
      port_en = 4'b1101;
      mark();
      frame(1, 2, 3, 0);
      idle(2);
      check("dis_nvalid", lg_nvalid - b_nvalid, 0);
      check("dis_ndone", lg_ndone - b_ndone, 1);
      check("dis_ndrop", lg_ndrop - b_ndrop, 1);

      // Port disabled only for the last payload bit
      port_en = 4'hF;
      mark();
      frame(1, 0, 0, 0);
      frame(1, 2, 0, 0);
      mark();
      send(11, 4, 0); send(1, 2, 0); send(2, 4, 0);
      step(0, 1, 0, 1);
      port_en = 4'b1101;
      step(0, 1, 0, 0);
      port_en = 4'hF;
      idle(2);
      check("late_dis_nvalid", lg_nvalid - b_nvalid, 1);
      check("late_dis_ndrop", lg_ndrop - b_ndrop, 1);

      // Abort on the 2nd payload bit of L=5, then a fresh frame
      mark();
      send(11, 4, 0); send(3, 2, 0); send(5, 4, 0);
      step(0, 1, 0, 1);
      step(0, 1, 1, 1);
      check("abort_busy", int'(busy), 0);
      send(3, 3, 0);
      frame(0, 1, 1, 0);
      idle(2);
      check("abort_nvalid", lg_nvalid - b_nvalid, 2);
      check("abort_ndone", lg_ndone - b_ndone, 1);
      check("abort_cur_port", int'(cur_port), 0);

      // Abort coinciding with the final payload bit
      mark();
      send(11, 4, 0); send(2, 2, 0); send(1, 4, 0);
      step(0, 1, 1, 1);
      idle(2);
      check("abort_last_ndone", lg_ndone - b_ndone, 0);
      check("abort_last_nvalid", lg_nvalid - b_nvalid, 0);

      // 1011011...: ADDR starts after the first 1011; payload containing 1011 is not a start
      mark();
      send(7'b1011011, 7, 0);
      send(3'b001, 3, 0);
      send(9'b101101011, 9, 0);
      idle(2);
      check("ovl_nvalid", lg_nvalid - b_nvalid, 9);
      check("ovl_bits", int'(lg_bits[8:0]), int'(9'b101101011));
      check("ovl_valid_mask", int'(lg_valid), 2);
      check("ovl_ndone", lg_ndone - b_ndone, 1);
      mark();
      send(6'b101011, 6, 0);
      send(2, 2, 0); send(1, 4, 0); send(0, 1, 0);
      idle(2);
      check("hunt_ovl_ndone", lg_ndone - b_ndone, 1);
      check("hunt_ovl_cur_port", int'(cur_port), 2);

      // Reset held 3 cycles mid-payload, then a normal frame
      send(11, 4, 0); send(3, 2, 0); send(4, 4, 0); send(3, 2, 0);
      step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_out_bit", int'(out_bit), 0);
      check("mid_rst_cur_port", int'(cur_port), 0);
      check("mid_rst_out_valid", int'(out_valid), 0);
      mark();
      frame(2, 1, 0, 0);
      idle(2);
      check("post_rst_ndone", lg_ndone - b_ndone, 1);
      check("post_rst_nvalid", lg_nvalid - b_nvalid, 1);
      check("post_rst_cur_port", int'(cur_port), 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
